// File: rtl/ifu_prefetch_fifo.sv
// ifu_prefetch_fifo
// -----------------
// Instruction-prefetch buffer between the IFU fetch request path and the
// decode/issue stage. All DEPTH entries are usable (pointers carry a wrap
// bit), occupancy is tracked in a registered count, and a synchronous flush
// empties the buffer on a branch redirect.
//
// Optional feature: define IFU_PREFETCH_FIFO_STATS_EN to add the max_level
// high-water-mark output.
//
// Handshake: a write is taken on any cycle with wr_en high and either
// wr_ready high or a read accepted in the same cycle; a read is taken on any
// cycle with rd_en high and the FIFO non-empty, and its data appears on
// rd_data with rd_valid high exactly one cycle later. Requests that are not
// taken set the sticky overflow/underflow flags. Flush overrides both.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   flush              discard all contents next cycle
//   wr_en, wr_data     write request and data; wr_ready = !full
//   rd_en              read request
//   rd_valid, rd_data  registered read response (rd_data holds when idle)
//   level              occupancy 0..DEPTH
//   empty, full        level == 0 / level == DEPTH
//   almost_full        level >= AF_LEVEL
//   almost_empty       level <= AE_LEVEL
//   overflow           sticky: a write was rejected
//   underflow          sticky: a read was rejected
//   err_clr            clears the sticky flags (and max_level when present)
//   max_level          (stats build only) highest level seen since clear
module ifu_prefetch_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
`ifdef IFU_PREFETCH_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]   max_level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              rd_fire, wr_fire;
    logic              ovf_set, unf_set;

    // Status decode from the registered count only.
    assign empty        = (count_q == '0);
    assign full         = (count_q == PW'(DEPTH));
    assign almost_full  = (count_q >= PW'(AF_LEVEL));
    assign almost_empty = (count_q <= PW'(AE_LEVEL));
    assign wr_ready     = ~full;
    assign level        = count_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Flush masks both requests, so nothing moves and no flag is set.
    // A full FIFO still takes a write when a read frees a slot this cycle;
    // an empty FIFO never forwards the incoming word to the reader.
    assign rd_fire = ~flush & rd_en & ~empty;
    assign wr_fire = ~flush & wr_en & (~full | rd_fire);
    assign ovf_set = ~flush & wr_en & ~wr_fire;
    assign unf_set = ~flush & rd_en & ~rd_fire;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_fire;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_fire) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
            end
            count_d = count_q + PW'(wr_fire) - PW'(rd_fire);
        end
        // A set event in the clear cycle wins.
        ovf_d = (ovf_q & ~err_clr) | ovf_set;
        unf_d = (unf_q & ~err_clr) | unf_set;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is not reset; stale words are never readable because the
    // count gates every read.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

`ifdef IFU_PREFETCH_FIFO_STATS_EN
    logic [PW-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (err_clr)             max_d = count_d;
        else if (count_d > max_q) max_d = count_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) max_q <= '0;
        else       max_q <= max_d;
    end

    assign max_level = max_q;
`endif

    // The count and the wrap-bit pointer distance must always agree.
    assert property (@(posedge clk) disable iff (!rstn)
        count_q == PW'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_ifu_prefetch_fifo.sv
// Bench for ifu_prefetch_fifo: directed phases with randomized data and
// request patterns, compared each cycle against a queue-based model.
module tb_ifu_prefetch_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int AE     = 2;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              rd_en = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [LW-1:0]     level;
    logic              empty, full, almost_full, almost_empty;
    logic              overflow, underflow;
    logic              err_clr = 1'b0;
`ifdef IFU_PREFETCH_FIFO_STATS_EN
    logic [LW-1:0]     max_level;
`endif

    ifu_prefetch_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .level(level), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`ifdef IFU_PREFETCH_FIFO_STATS_EN
        , .max_level(max_level)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the queue holds the buffered words in order.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_rd_data;
    bit                m_rd_valid, m_ovf, m_unf;
    int                m_max;
    int                n_pass  = 0;
    int                n_fail  = 0;
    int                n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 0;
        m_ovf      = 0;
        m_unf      = 0;
        m_max      = 0;
    endtask

    task automatic check_outputs();
        int n;
        n = exp_q.size();
        chk("level",        32'(level),        32'(n));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("wr_ready",     32'(wr_ready),     32'(n != DEPTH));
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        chk("rd_data",      rd_data,           m_rd_data);
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
`ifdef IFU_PREFETCH_FIFO_STATS_EN
        chk("max_level",    32'(max_level),    32'(m_max));
`endif
    endtask

    // One clock: drive, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input bit w, input logic [DATA_W-1:0] d, input bit r,
                         input bit f, input bit ec);
        bit rf, wf, set_o, set_u;
        wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec;
        set_o = 0; set_u = 0;
        if (f) begin
            exp_q.delete();
            m_rd_valid = 0;
        end else begin
            rf = r && (exp_q.size() > 0);
            wf = w && ((exp_q.size() < DEPTH) || rf);
            m_rd_valid = rf;
            if (rf) m_rd_data = exp_q.pop_front();
            if (wf) exp_q.push_back(d);
            set_o = w && !wf;
            set_u = r && !rf;
        end
        m_ovf = (ec ? 1'b0 : m_ovf) | set_o;
        m_unf = (ec ? 1'b0 : m_unf) | set_u;
        if (ec) m_max = exp_q.size();
        else if (exp_q.size() > m_max) m_max = exp_q.size();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, 0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        cycle(1, d, 0, 0, 0);
    endtask

    task automatic pop();
        cycle(0, '0, 1, 0, 0);
    endtask

    initial begin
        int writes, guard;
        bit w, r;
        logic [DATA_W-1:0] tail_word;

        // Reset is asynchronous: outputs settle with no clock edge.
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Six words 0x11..0x16.
        for (int i = 0; i < 6; i++) push(DATA_W'(32'h11 + i));

        // Fill to 16, then one rejected write.
        for (int i = 6; i < DEPTH; i++) push(DATA_W'($urandom));
        push(32'hDEAD_BEEF);

        // Drain all 16 in order.
        for (int i = 0; i < DEPTH; i++) pop();
        idle();

        // Clear flags, refill, then simultaneous write+read on full.
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) push(DATA_W'($urandom));
        tail_word = DATA_W'($urandom);
        cycle(1, tail_word, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) pop();
        chk("full_rw_tail", rd_data, tail_word);
        idle();

        // Empty FIFO: read and write together, read is rejected.
        cycle(1, 32'hAB, 1, 0, 0);
        pop();
        chk("empty_rw_word", rd_data, 32'hAB);

        // Streaming: 40 writes while keeping occupancy around 4..8.
        cycle(0, '0, 0, 0, 1);
        writes = 0;
        guard  = 0;
        while (writes < 40 && guard < 1000) begin
            w = ($urandom_range(0, 3) != 0);
            r = (exp_q.size() >= 8) || ((exp_q.size() >= 4) && ($urandom_range(0, 1) == 1));
            if (w) writes++;
            cycle(w, DATA_W'($urandom), r, 0, 0);
            guard++;
        end
        chk("stream_budget", 32'(writes), 32'd40);
        while (exp_q.size() > 0) pop();

        // Clear together with a rejected read: the set wins.
        cycle(0, '0, 1, 0, 1);

        // Ten words, then flush with both requests asserted.
        for (int i = 0; i < 10; i++) push(DATA_W'($urandom));
        cycle(1, DATA_W'($urandom), 1, 1, 0);
        idle();
        cycle(0, '0, 0, 0, 1);

        // Reset in the middle of operation.
        for (int i = 0; i < 5; i++) push(DATA_W'($urandom));
        cycle(1, DATA_W'($urandom), 1, 0, 0);
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 20; i++)
            cycle($urandom_range(0, 1), DATA_W'($urandom), $urandom_range(0, 1), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch_fifo.md
Name: ifu_prefetch_fifo

Overview:
- Parametrised instruction-prefetch buffer between the IFU fetch request path and the decode/issue stage.
- Generalises the single-threshold IFU FIFO:
  - full DEPTH usable entries, via an extra pointer wrap bit
  - live occupancy count
  - independent almost-full and almost-empty levels
  - write accepted on a full FIFO when a read fires in the same cycle
  - synchronous flush for branch redirect
  - sticky overflow/underflow error flags

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 16, number of entries. Power of two, >= 4.
- AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all contents (branch redirect).
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  high when !full.
- rd_en  in  1  read request.
- rd_valid  out  1  registered; high the cycle after an accepted read.
- rd_data  out  DATA_W  registered read data; holds its value when rd_valid is low.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  clears overflow and underflow (and max_level when the optional feature is compiled in).

Behaviour:
- Reset: asynchronous, active-low; all outputs and state are asserted to reset values immediately.
  - wr_ptr, rd_ptr, level, rd_data, rd_valid, overflow, underflow = 0.
  - empty = 1, almost_empty = 1, wr_ready = 1, full = 0, almost_full = 0.
  - Memory array is not reset.
  - Reset mid-operation discards all contents and any pending read.
- Pointers: $clog2(DEPTH)+1 bits each; low bits index the array, MSB is the wrap bit.
- Status outputs: full, empty and level are derived from the registered count. almost_* and wr_ready are combinational from the registered level, so they add no latency beyond the count update.
- Read accept: rd_fire = rd_en & !empty.
  - On rd_fire: rd_data <= mem[rd_ptr], rd_valid <= 1 next cycle, rd_ptr increments.
  - Otherwise: rd_valid <= 0.
  - Read latency is exactly 1 cycle.
- Write accept: wr_fire = wr_en & (!full | rd_fire).
  - On wr_fire: mem[wr_ptr] <= wr_data, wr_ptr increments.
  - A write and read in the same cycle on a full FIFO are both accepted; level stays at DEPTH.
  - On an empty FIFO, rd_en with wr_en does not bypass: the read is rejected and underflow sets.
- Level update: level_next = level + wr_fire - rd_fire. Never exceeds DEPTH and never drops below 0.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 with no special handling.
- Error flags:
  - overflow sets on wr_en & !wr_fire.
  - underflow sets on rd_en & !rd_fire.
  - Both remain set until err_clr. A set event in the same cycle as err_clr wins, so the flag stays 1.
- Flush: highest priority below reset.
  - Next cycle: pointers = 0, level = 0, rd_valid = 0.
  - wr_en and rd_en in the flush cycle are ignored and do not set error flags.
  - rd_data keeps its old value. Sticky flags are not affected.
- No state machine beyond the pointers and count. The intended RTL size is 150-250 lines.

Optional Feature:
- Macro: IFU_PREFETCH_FIFO_STATS_EN.
- Defined:
  - Adds output port max_level, width $clog2(DEPTH)+1, reset 0.
  - Each cycle, max_level <= max(max_level, level_next). Flush does not lower it.
  - err_clr loads the current level_next.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then write 0x11..0x16 (6 words), DEPTH=16 -> level=6; almost_empty 0 once level reaches 3; empty=0; no flags set.
- Fill to 16 words, then one more wr_en without rd_en -> full=1, wr_ready=0, word rejected, overflow=1 the next cycle. Drain 16 reads -> rd_data returns the first 16 words in order, each 1 cycle after its rd_en.
- Full FIFO, wr_en and rd_en in the same cycle -> both accepted, level stays 16, overflow stays 0. The new word is read back last after a full drain.
- Empty FIFO, rd_en and wr_en=0xAB in the same cycle -> rd_valid=0, underflow=1, level=1. The next rd_en returns 0xAB.
- Write 40 words while reading continuously at depth 4-8 -> pointers wrap twice, no data corruption, level matches the scoreboard every cycle. err_clr with a simultaneous rejected read -> underflow stays 1.
- With 10 words held, assert flush together with wr_en/rd_en -> next cycle level=0, empty=1, rd_valid=0, flags unchanged. With IFU_PREFETCH_FIFO_STATS_EN defined -> max_level=10 after the flush, and err_clr sets it to 0.
